kf8259_ack_sequencer: RTL and testbench

KF8259_ACK_SEQUENCER -- requirements
Module: kf8259_ack_sequencer

---
 rtl/kf8259_ack_sequencer_pkg.sv | 36 +++
 rtl/kf8259_ack_sequencer_ocw2_decoder.sv | 55 +++++
 rtl/kf8259_ack_sequencer.sv | 127 ++++++++++++
 tb/tb_kf8259_ack_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf8259_ack_sequencer_pkg.sv
// Shared types for the 8259 acknowledge path: ack-state enum, OCW2 command codes, level encoders.
// Latency: n/a (types and pure functions). Backpressure: n/a.
// Included by the acknowledge sequencer and its OCW2 decoder.
package KF8259_Common_Package;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } ack_state_t;

    // OCW2 {R, SL, EOI} command field
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    function automatic logic [2:0] onehot_to_bin(input logic [7:0] onehot);
        logic [2:0] bin;
        bin = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) bin = bin | 3'(i);
        end
        return bin;
    endfunction

    function automatic logic [7:0] bin_to_onehot(input logic [2:0] bin);
        return 8'(1) << bin;
    endfunction

endpackage

// File: rtl/kf8259_ack_sequencer_ocw2_decoder.sv
// Decodes an OCW2 strobe into an ISR clear mask, a rotate load and AEOI-rotate mode changes.
// Latency: combinational, 0 cycles. Backpressure: none, strobe is consumed the cycle it arrives.
module kf8259_ocw2_decoder
    import KF8259_Common_Package::*;
(
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    input  logic [7:0] highest_level_in_service,
    output logic [7:0] eoi_mask,
    output logic       rotate_load,
    output logic [2:0] rotate_value,
    output logic       aeoi_rotate_set,
    output logic       aeoi_rotate_clear
);
    logic [2:0] command;
    logic [2:0] level;
    logic       unused_bits;

    assign command     = ocw2_data[7:5];
    assign level       = ocw2_data[2:0];
    assign unused_bits = ^ocw2_data[4:3];

    always_comb begin
        eoi_mask          = 8'h00;
        rotate_load       = 1'b0;
        rotate_value      = 3'd0;
        aeoi_rotate_set   = 1'b0;
        aeoi_rotate_clear = 1'b0;
        if (ocw2_write) begin
            case (command)
                OCW2_NS_EOI: eoi_mask = highest_level_in_service;
                OCW2_SP_EOI: eoi_mask = bin_to_onehot(level);
                OCW2_ROT_NS_EOI: begin
                    // Nothing in service: no clear and the rotation point stays put.
                    eoi_mask     = highest_level_in_service;
                    rotate_load  = |highest_level_in_service;
                    rotate_value = onehot_to_bin(highest_level_in_service);
                end
                OCW2_ROT_SP_EOI: begin
                    eoi_mask     = bin_to_onehot(level);
                    rotate_load  = 1'b1;
                    rotate_value = level;
                end
                OCW2_ROT_AEOI_SET: aeoi_rotate_set   = 1'b1;
                OCW2_ROT_AEOI_CLR: aeoi_rotate_clear = 1'b1;
                OCW2_SET_PRIO: begin
                    rotate_load  = 1'b1;
                    rotate_value = level;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kf8259_ack_sequencer.sv
// Runs the two-pulse INTA handshake: raises INT, latches the ISR bit, drives the vector, issues AEOI/OCW2 EOIs.
// Latency: strobes and flags one cycle after the sampled INTA edge or OCW2 write; vector drive follows INTA directly.
// Backpressure: none, the CPU paces the handshake through INTA.
module kf8259_ack_sequencer
    import KF8259_Common_Package::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_acknowledge_n,
    input  logic [7:0] highest_priority_request,
    input  logic [7:0] highest_level_in_service,
    input  logic       auto_eoi,
    input  logic [4:0] vector_base,
    input  logic       icw1_write,
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    output logic       interrupt,
    output logic       latch_in_service,
    output logic [7:0] interrupt_to_latch,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic       freeze,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_enable
);
    ack_state_t state, state_next;
    logic       inta_prev;
    logic       inta_fall, inta_rise;
    logic       ack_start, ack_done, aeoi_fire;
    logic [7:0] ack_level;
    logic       spurious;
    logic       rotate_in_aeoi;

    logic [7:0] ocw2_eoi_mask;
    logic       ocw2_rotate_load;
    logic [2:0] ocw2_rotate_value;
    logic       aeoi_rotate_set, aeoi_rotate_clear;

    kf8259_ocw2_decoder u_ocw2_decoder (
        .ocw2_write               (ocw2_write),
        .ocw2_data                (ocw2_data),
        .highest_level_in_service (highest_level_in_service),
        .eoi_mask                 (ocw2_eoi_mask),
        .rotate_load              (ocw2_rotate_load),
        .rotate_value             (ocw2_rotate_value),
        .aeoi_rotate_set          (aeoi_rotate_set),
        .aeoi_rotate_clear        (aeoi_rotate_clear)
    );

    assign inta_fall = inta_prev & ~interrupt_acknowledge_n;
    assign inta_rise = ~inta_prev & interrupt_acknowledge_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (inta_fall) state_next = ST_ACK1;
            ST_ACK1:  if (inta_rise) state_next = ST_WAIT2;
            ST_WAIT2: if (inta_fall) state_next = ST_ACK2;
            ST_ACK2:  if (inta_rise) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (icw1_write) state_next = ST_IDLE;
    end

    assign ack_start = (state == ST_IDLE) & inta_fall & ~icw1_write;
    assign ack_done  = (state == ST_ACK2) & inta_rise & ~icw1_write;
    assign aeoi_fire = ack_done & auto_eoi & ~spurious;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inta_prev          <= 1'b1;
            interrupt          <= 1'b0;
            latch_in_service   <= 1'b0;
            interrupt_to_latch <= 8'h00;
            end_of_interrupt   <= 8'h00;
            priority_rotate    <= 3'd7;
            rotate_in_aeoi     <= 1'b0;
            freeze             <= 1'b0;
            ack_level          <= 8'h00;
            spurious           <= 1'b0;
        end else begin
            inta_prev          <= interrupt_acknowledge_n;
            latch_in_service   <= 1'b0;
            interrupt_to_latch <= 8'h00;
            if (icw1_write) begin
                interrupt        <= 1'b0;
                end_of_interrupt <= 8'h00;
                priority_rotate  <= 3'd7;
                rotate_in_aeoi   <= 1'b0;
                freeze           <= 1'b0;
                spurious         <= 1'b0;
            end else begin
                end_of_interrupt <= ocw2_eoi_mask | (aeoi_fire ? ack_level : 8'h00);
                if (ack_start) begin
                    // An empty request at INTA is answered as a spurious level 7.
                    ack_level          <= (|highest_priority_request) ? highest_priority_request : 8'h80;
                    spurious           <= ~(|highest_priority_request);
                    latch_in_service   <= |highest_priority_request;
                    interrupt_to_latch <= highest_priority_request;
                    interrupt          <= 1'b0;
                    freeze             <= 1'b1;
                end else if ((state == ST_IDLE) && (|highest_priority_request)) begin
                    interrupt <= 1'b1;
                end
                if (ack_done) freeze <= 1'b0;
                // An explicit OCW2 rotate outranks the automatic one.
                if (ocw2_rotate_load)
                    priority_rotate <= ocw2_rotate_value;
                else if (aeoi_fire && rotate_in_aeoi)
                    priority_rotate <= onehot_to_bin(ack_level);
                if (aeoi_rotate_set)
                    rotate_in_aeoi <= 1'b1;
                else if (aeoi_rotate_clear)
                    rotate_in_aeoi <= 1'b0;
            end
        end
    end

    assign data_bus_out_enable = (state == ST_ACK2) & ~interrupt_acknowledge_n;
    assign data_bus_out        = (state == ST_ACK2) ? {vector_base, onehot_to_bin(ack_level)} : 8'h00;

endmodule

// File: tb/tb_kf8259_ack_sequencer.sv
// Directed and randomized INTA / OCW2 / ICW1 sequences against a transaction-level expectation model.
module tb_kf8259_ack_sequencer;
    logic       clock;
    logic       reset;
    logic       interrupt_acknowledge_n;
    logic [7:0] highest_priority_request;
    logic [7:0] highest_level_in_service;
    logic       auto_eoi;
    logic [4:0] vector_base;
    logic       icw1_write;
    logic       ocw2_write;
    logic [7:0] ocw2_data;
    logic       interrupt;
    logic       latch_in_service;
    logic [7:0] interrupt_to_latch;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic       freeze;
    logic [7:0] data_bus_out;
    logic       data_bus_out_enable;

    int checks = 0;
    int errors = 0;
    int model_rot = 7;
    int model_raeoi = 0;

    kf8259_ack_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt_acknowledge_n  (interrupt_acknowledge_n),
        .highest_priority_request (highest_priority_request),
        .highest_level_in_service (highest_level_in_service),
        .auto_eoi                 (auto_eoi),
        .vector_base              (vector_base),
        .icw1_write               (icw1_write),
        .ocw2_write               (ocw2_write),
        .ocw2_data                (ocw2_data),
        .interrupt                (interrupt),
        .latch_in_service         (latch_in_service),
        .interrupt_to_latch       (interrupt_to_latch),
        .end_of_interrupt         (end_of_interrupt),
        .priority_rotate          (priority_rotate),
        .freeze                   (freeze),
        .data_bus_out             (data_bus_out),
        .data_bus_out_enable      (data_bus_out_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int level_of(input logic [7:0] onehot);
        for (int i = 0; i < 8; i++) if (onehot[i]) return i;
        return 7;
    endfunction

    function automatic logic [7:0] rand_onehot_or_zero();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 8'h00 : (8'(1) << r);
    endfunction

    // Expected effect of an OCW2 byte: returns the clear mask and updates the rotate/AEOI-mode model.
    task automatic ocw_model(input logic [7:0] d, input logic [7:0] hls_v, output logic [7:0] mask);
        int l;
        l = int'(d[2:0]);
        mask = 8'h00;
        case (d[7:5])
            3'b001: mask = hls_v;
            3'b011: mask = 8'(1) << l;
            3'b101: begin
                mask = hls_v;
                if (hls_v != 8'h00) model_rot = level_of(hls_v);
            end
            3'b111: begin
                mask = 8'(1) << l;
                model_rot = l;
            end
            3'b100: model_raeoi = 1;
            3'b000: model_raeoi = 0;
            3'b110: model_rot = l;
            default: ;
        endcase
    endtask

    task automatic do_ocw(input logic [7:0] d, input logic [7:0] hls_v);
        logic [7:0] mask;
        ocw_model(d, hls_v, mask);
        ocw2_write = 1'b1;
        ocw2_data = d;
        highest_level_in_service = hls_v;
        step();
        ocw2_write = 1'b0;
        check("ocw_eoi", 32'(end_of_interrupt), 32'(mask));
        check("ocw_rotate", 32'(priority_rotate), 32'(model_rot));
        step();
        check("ocw_eoi_clear", 32'(end_of_interrupt), 32'(0));
    endtask

    task automatic run_ack(input logic [7:0] req, input logic aeoi, input logic [4:0] vb,
                           input logic ocw_en, input logic [7:0] ocw_byte, input logic [7:0] hls_v);
        logic       spur;
        int         idx;
        logic [7:0] exp_eoi;
        logic [7:0] ocw_mask;
        spur = (req == 8'h00);
        idx = spur ? 7 : level_of(req);
        highest_priority_request = req;
        auto_eoi = aeoi;
        vector_base = vb;
        step();
        check("int_raise", 32'(interrupt), 32'(!spur));
        interrupt_acknowledge_n = 1'b0;
        step();
        check("latch_pulse", 32'(latch_in_service), 32'(!spur));
        check("latch_level", 32'(interrupt_to_latch), 32'(spur ? 8'h00 : req));
        check("int_clear", 32'(interrupt), 32'(0));
        check("freeze_set", 32'(freeze), 32'(1));
        check("dboe_ack1", 32'(data_bus_out_enable), 32'(0));
        highest_priority_request = 8'h00;
        step();
        check("latch_one_cycle", 32'(latch_in_service), 32'(0));
        interrupt_acknowledge_n = 1'b1;
        step();
        check("dboe_wait2", 32'(data_bus_out_enable), 32'(0));
        interrupt_acknowledge_n = 1'b0;
        step();
        check("dboe_ack2", 32'(data_bus_out_enable), 32'(1));
        check("vector", 32'(data_bus_out), 32'({vb, 3'(idx)}));
        check("freeze_hold", 32'(freeze), 32'(1));
        interrupt_acknowledge_n = 1'b1;
        exp_eoi = (aeoi && !spur) ? (8'(1) << idx) : 8'h00;
        if (aeoi && !spur && model_raeoi == 1) model_rot = idx;
        if (ocw_en) begin
            ocw_model(ocw_byte, hls_v, ocw_mask);
            exp_eoi = exp_eoi | ocw_mask;
            ocw2_write = 1'b1;
            ocw2_data = ocw_byte;
            highest_level_in_service = hls_v;
        end
        #1;
        check("dboe_inta_high", 32'(data_bus_out_enable), 32'(0));
        step();
        ocw2_write = 1'b0;
        check("ack_eoi", 32'(end_of_interrupt), 32'(exp_eoi));
        check("ack_rotate", 32'(priority_rotate), 32'(model_rot));
        check("freeze_clear", 32'(freeze), 32'(0));
        step();
        check("ack_eoi_clear", 32'(end_of_interrupt), 32'(0));
        check("int_idle", 32'(interrupt), 32'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_int"}, 32'(interrupt), 32'(0));
        check({tag, "_latch"}, 32'(latch_in_service), 32'(0));
        check({tag, "_itl"}, 32'(interrupt_to_latch), 32'(0));
        check({tag, "_eoi"}, 32'(end_of_interrupt), 32'(0));
        check({tag, "_rot"}, 32'(priority_rotate), 32'(7));
        check({tag, "_freeze"}, 32'(freeze), 32'(0));
        check({tag, "_dbo"}, 32'(data_bus_out), 32'(0));
        check({tag, "_dboe"}, 32'(data_bus_out_enable), 32'(0));
    endtask

    initial begin
        reset = 1'b1;
        interrupt_acknowledge_n = 1'b1;
        highest_priority_request = 8'h00;
        highest_level_in_service = 8'h00;
        auto_eoi = 1'b0;
        vector_base = 5'h00;
        icw1_write = 1'b0;
        ocw2_write = 1'b0;
        ocw2_data = 8'h00;
        #1;
        check_reset_values("rst");
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_values("post_rst");

        // Basic acknowledge of level 2 with vector base 1
        run_ack(8'h04, 1'b0, 5'h01, 1'b0, 8'h00, 8'h00);

        // Auto-EOI with rotate-in-AEOI enabled
        do_ocw(8'h80, 8'h00);
        run_ack(8'h20, 1'b1, 5'h0A, 1'b0, 8'h00, 8'h00);
        check("aeoi_rot5", 32'(priority_rotate), 32'(5));

        // Rotate on non-specific EOI, then with nothing in service
        do_ocw(8'hA0, 8'h08);
        check("ns_rot3", 32'(priority_rotate), 32'(3));
        do_ocw(8'hA0, 8'h00);
        check("ns_empty_rot", 32'(priority_rotate), 32'(3));

        // Spurious acknowledge
        run_ack(8'h00, 1'b1, 5'h1F, 1'b0, 8'h00, 8'h00);

        // Auto-EOI coinciding with a specific EOI
        do_ocw(8'h00, 8'h00);
        run_ack(8'h01, 1'b1, 5'h02, 1'b1, 8'h63, 8'h00);
        check("aeoi_ocw_rot", 32'(priority_rotate), 32'(3));

        // Reset in the middle of ACK2 with INTA low
        highest_priority_request = 8'h10;
        step();
        interrupt_acknowledge_n = 1'b0;
        step();
        highest_priority_request = 8'h00;
        step();
        interrupt_acknowledge_n = 1'b1;
        step();
        interrupt_acknowledge_n = 1'b0;
        step();
        check("pre_reset_dboe", 32'(data_bus_out_enable), 32'(1));
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        model_rot = 7;
        model_raeoi = 0;
        step();
        interrupt_acknowledge_n = 1'b1;
        step();
        reset = 1'b0;
        step();
        check_reset_values("mid_rst_hold");
        run_ack(8'h02, 1'b1, 5'h05, 1'b0, 8'h00, 8'h00);

        // ICW1 aborts an acknowledge in progress
        do_ocw(8'hC2, 8'h00);
        do_ocw(8'h80, 8'h00);
        highest_priority_request = 8'h40;
        step();
        check("icw_pre_int", 32'(interrupt), 32'(1));
        interrupt_acknowledge_n = 1'b0;
        step();
        check("icw_pre_freeze", 32'(freeze), 32'(1));
        highest_priority_request = 8'h00;
        icw1_write = 1'b1;
        step();
        icw1_write = 1'b0;
        model_rot = 7;
        model_raeoi = 0;
        check("icw_freeze", 32'(freeze), 32'(0));
        check("icw_int", 32'(interrupt), 32'(0));
        check("icw_latch", 32'(latch_in_service), 32'(0));
        check("icw_eoi", 32'(end_of_interrupt), 32'(0));
        check("icw_rot", 32'(priority_rotate), 32'(7));
        interrupt_acknowledge_n = 1'b1;
        step();
        step();
        check("icw_dboe", 32'(data_bus_out_enable), 32'(0));
        run_ack(8'h08, 1'b1, 5'h11, 1'b0, 8'h00, 8'h00);
        check("icw_aeoi_cleared_rot", 32'(priority_rotate), 32'(7));

        // Randomized mixes of OCW2 commands and acknowledge sequences
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_ocw(8'($urandom), rand_onehot_or_zero());
            run_ack(rand_onehot_or_zero(), 1'($urandom), 5'($urandom),
                    1'($urandom), 8'($urandom), rand_onehot_or_zero());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
